// File: rtl/signed_adder_tree.sv
// ----------------------------------------------------------------------------
// signed_adder_tree
//
// Pipelined N-input signed adder. NUM_IN signed lanes are reduced through a
// registered binary tree (one register level per halving), followed by one
// output register that narrows the full-precision sum to OWIDTH bits with
// either wrap-around or saturation and raises a per-sample overflow flag.
// A valid bit travels alongside the data, and a clock enable freezes every
// register in the block.
//
// Parameters
//   IWIDTH    width of each signed input lane
//   NUM_IN    number of lanes (>= 2)
//   OWIDTH    output width; default is full precision IWIDTH + $clog2(NUM_IN)
//   SATURATE  only used when OWIDTH is below full precision: 1 = clamp,
//             0 = wrap (drop MSBs)
//
// Ports
//   i_clk     clock, rising edge
//   i_rst     asynchronous active-high reset; clears every register
//   i_ce      clock enable; 0 holds the whole pipeline including outputs
//   i_valid   input sample valid
//   i_data    packed signed lanes, lane k = i_data[k*IWIDTH +: IWIDTH]
//   o_valid   output sample valid (latency $clog2(NUM_IN) + 1 enabled cycles)
//   o_sum     signed sum, OWIDTH bits
//   o_ovf     the sample did not fit in OWIDTH (clamped or wrapped)
// ----------------------------------------------------------------------------
module signed_adder_tree #(
    parameter int IWIDTH   = 16,
    parameter int NUM_IN   = 4,
    parameter int OWIDTH   = IWIDTH + $clog2(NUM_IN),
    parameter int SATURATE = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_ce,
    input  logic                       i_valid,
    input  logic [NUM_IN*IWIDTH-1:0]   i_data,
    output logic                       o_valid,
    output logic [OWIDTH-1:0]          o_sum,
    output logic                       o_ovf
);

    // Guard against NUM_IN < 2 so the widths below stay sane while the
    // elaboration error is being reported.
    localparam int LEVELS = (NUM_IN < 2) ? 1 : $clog2(NUM_IN);
    localparam int FWID   = IWIDTH + LEVELS;
    localparam int LAT    = LEVELS + 1;
    // Common width for the range test: wide enough for both the full sum
    // and the output, so one signed comparison covers every configuration.
    localparam int XW     = (OWIDTH > FWID) ? OWIDTH : FWID;
    localparam bit CLAMP  = (SATURATE != 0);

    localparam logic signed [XW-1:0] O_MAX = {{(XW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] O_MIN = {{(XW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

    // Number of operands entering tree level l: ceil(NUM_IN / 2^l).
    function automatic int cnt_at(input int l);
        return (NUM_IN + (1 << l) - 1) >> l;
    endfunction

    genvar gi, ki;

    generate
        if (NUM_IN < 2 || OWIDTH < IWIDTH) begin : g_param_err
            $error("signed_adder_tree: NUM_IN must be >= 2 and OWIDTH >= IWIDTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Adder tree. Level gi takes operands of IWIDTH+gi bits and produces
    // sums one bit wider, so no level can overflow. Operands are paired
    // (2j, 2j+1); an odd leftover is paired with a constant zero, which
    // amounts to a sign-extending pass-through register.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
            localparam int W_IN  = IWIDTH + gi;
            localparam int W_OUT = W_IN + 1;
            localparam int N_IN  = cnt_at(gi);
            localparam int N_OUT = cnt_at(gi + 1);

            logic signed [W_IN-1:0]  opnd  [2*N_OUT];
            logic signed [W_OUT-1:0] sum_d [N_OUT];
            logic signed [W_OUT-1:0] sum_q [N_OUT];

            for (ki = 0; ki < N_IN; ki++) begin : g_src
                if (gi == 0) begin : g_lane
                    assign opnd[ki] = i_data[ki*IWIDTH +: IWIDTH];
                end else begin : g_prev
                    assign opnd[ki] = g_lvl[gi-1].sum_q[ki];
                end
            end

            if (N_IN < 2*N_OUT) begin : g_pad
                assign opnd[2*N_OUT-1] = '0;
            end

            always_comb begin
                for (int j = 0; j < N_OUT; j++) begin
                    sum_d[j] = {opnd[2*j][W_IN-1], opnd[2*j]}
                             + {opnd[2*j+1][W_IN-1], opnd[2*j+1]};
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    sum_q <= '{default: '0};
                end else if (i_ce) begin
                    sum_q <= sum_d;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stage: narrowing and overflow detection.
    // ------------------------------------------------------------------
    logic signed [FWID-1:0]  full_sum;
    logic signed [XW-1:0]    full_ext;
    logic                    fits;
    logic [OWIDTH-1:0]       sum_out_d;
    logic [OWIDTH-1:0]       sum_out_q;
    logic                    ovf_d;
    logic                    ovf_q;
    logic [LAT-1:0]          vld_d;
    logic [LAT-1:0]          vld_q;

    assign full_sum = g_lvl[LEVELS-1].sum_q[0];

    always_comb begin
        full_ext  = XW'(full_sum);
        // When OWIDTH covers full precision this is constant-true and the
        // whole narrowing path reduces to a sign extension.
        fits      = (full_ext >= O_MIN) && (full_ext <= O_MAX);
        sum_out_d = full_ext[OWIDTH-1:0];
        ovf_d     = ~fits;
        if (!fits && CLAMP) begin
            sum_out_d = full_ext[XW-1] ? O_MIN[OWIDTH-1:0] : O_MAX[OWIDTH-1:0];
        end
    end

    // Valid pipe runs in lock-step with the data: LEVELS tree stages plus
    // the output register.
    always_comb begin
        vld_d = {vld_q[LAT-2:0], i_valid};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q     <= '0;
            sum_out_q <= '0;
            ovf_q     <= 1'b0;
        end else if (i_ce) begin
            vld_q     <= vld_d;
            sum_out_q <= sum_out_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_valid = vld_q[LAT-1];
    assign o_sum   = sum_out_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_signed_adder_tree.sv
// ----------------------------------------------------------------------------
// tb_signed_adder_tree
//
// Four instances share clock, reset, enable and valid:
//   u_full : NUM_IN=4, OWIDTH=18 (full precision), latency 3
//   u_sat  : NUM_IN=4, OWIDTH=16, saturating,       latency 3
//   u_wrap : NUM_IN=4, OWIDTH=16, wrapping,         latency 3
//   u_five : NUM_IN=5, OWIDTH=19 (full precision), latency 4
// The 4-lane instances see the low four lanes of the 5-lane bus.
// A background monitor records every enabled input and predicts each output
// as "the sample accepted L enabled edges ago", summed and narrowed with
// plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_signed_adder_tree;

    localparam int IW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        valid;
    logic [79:0] data5;
    logic [63:0] data4;

    logic        v_full, v_sat, v_wrap, v_five;
    logic [17:0] s_full;
    logic [15:0] s_sat, s_wrap;
    logic [18:0] s_five;
    logic        o_full, o_sat, o_wrap, o_five;

    assign data4 = data5[63:0];

    signed_adder_tree #(.IWIDTH(16), .NUM_IN(4), .OWIDTH(18), .SATURATE(0)) u_full (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(valid), .i_data(data4),
        .o_valid(v_full), .o_sum(s_full), .o_ovf(o_full));

    signed_adder_tree #(.IWIDTH(16), .NUM_IN(4), .OWIDTH(16), .SATURATE(1)) u_sat (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(valid), .i_data(data4),
        .o_valid(v_sat), .o_sum(s_sat), .o_ovf(o_sat));

    signed_adder_tree #(.IWIDTH(16), .NUM_IN(4), .OWIDTH(16), .SATURATE(0)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(valid), .i_data(data4),
        .o_valid(v_wrap), .o_sum(s_wrap), .o_ovf(o_wrap));

    signed_adder_tree #(.IWIDTH(16), .NUM_IN(5), .OWIDTH(19), .SATURATE(0)) u_five (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_valid(valid), .i_data(data5),
        .o_valid(v_five), .o_sum(s_five), .o_ovf(o_five));

    initial forever #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference history: one entry per enabled edge since the last reset.
    bit hv[$];
    int hs4[$];
    int hs5[$];
    int k_en = 0;

    typedef struct {
        int l0, l1, l2, l3;
        int full;
        int sat;
        int sat_ovf;
        int wrap;
        int wrap_ovf;
    } vec_t;

    vec_t tbl[10];

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    function automatic int lane(input int n);
        return int'($signed(data5[n*IW +: IW]));
    endfunction

    function automatic void narrow(input int s, input int ow, input bit sat,
                                   output int r, output int ovf);
        longint span;
        longint m;
        int     lo;
        int     hi;
        span = 64'sd1 << ow;
        lo   = -(1 << (ow - 1));
        hi   = (1 << (ow - 1)) - 1;
        if (s >= lo && s <= hi) begin
            r   = s;
            ovf = 0;
        end else begin
            ovf = 1;
            if (sat) begin
                r = (s < 0) ? lo : hi;
            end else begin
                m = (longint'(s) - lo) % span;
                if (m < 0) m += span;
                r = int'(m + lo);
            end
        end
    endfunction

    function automatic void set_vec(input int i, input int a, input int b, input int c,
                                    input int d, input int f, input int sv, input int so,
                                    input int wv, input int wo);
        tbl[i].l0 = a; tbl[i].l1 = b; tbl[i].l2 = c; tbl[i].l3 = d;
        tbl[i].full = f;
        tbl[i].sat = sv; tbl[i].sat_ovf = so;
        tbl[i].wrap = wv; tbl[i].wrap_ovf = wo;
    endfunction

    task automatic mon(input string nm, input int lat, input int ow, input bit sat,
                       input bit five, input logic v, input int s, input logic o);
        int idx;
        int ev, es, eo;
        idx = k_en - lat;
        if (idx < 0) begin
            ev = 0; es = 0; eo = 0;
        end else begin
            ev = int'(hv[idx]);
            narrow(five ? hs5[idx] : hs4[idx], ow, sat, es, eo);
        end
        chk($sformatf("mon %s o_valid k=%0d", nm, k_en), int'(v), ev);
        chk($sformatf("mon %s o_sum k=%0d", nm, k_en), s, es);
        chk($sformatf("mon %s o_ovf k=%0d", nm, k_en), int'(o), eo);
    endtask

    always begin
        @(posedge clk);
        if (!rst && ce) begin
            hv.push_back(valid);
            hs4.push_back(lane(0) + lane(1) + lane(2) + lane(3));
            hs5.push_back(lane(0) + lane(1) + lane(2) + lane(3) + lane(4));
            k_en++;
        end
        #1;
        if (!rst) begin
            mon("full", 3, 18, 1'b0, 1'b0, v_full, int'($signed(s_full)), o_full);
            mon("sat",  3, 16, 1'b1, 1'b0, v_sat,  int'($signed(s_sat)),  o_sat);
            mon("wrap", 3, 16, 1'b0, 1'b0, v_wrap, int'($signed(s_wrap)), o_wrap);
            mon("five", 4, 19, 1'b0, 1'b1, v_five, int'($signed(s_five)), o_five);
        end
    end

    task automatic apply(input bit v, input int a, input int b, input int c,
                         input int d, input int e);
        valid = v;
        data5 = {e[15:0], d[15:0], c[15:0], b[15:0], a[15:0]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        hv.delete();
        hs4.delete();
        hs5.delete();
        k_en = 0;
    endtask

    function automatic int rnd_lane();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 32767;
        if (r == 1) return -32768;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    int  got[$];
    int  s5l[10][5];
    int  exp5[10];
    int  idx;
    bit  take;

    initial begin
        set_vec(0,  32767,  32767,  32767,  32767,  131068,  32767, 1,     -4, 1);
        set_vec(1, -32768, -32768, -32768, -32768, -131072, -32768, 1,      0, 1);
        set_vec(2,    100,   -200,    300,   -400,    -200,   -200, 0,   -200, 0);
        set_vec(3,  20000,  20000,  20000,  20000,   80000,  32767, 1,  14464, 1);
        set_vec(4, -20000, -20000, -20000, -20000,  -80000, -32768, 1, -14464, 1);
        set_vec(5,     10,     20,     30,     40,     100,    100, 0,    100, 0);
        set_vec(6,  32767,      1,      0,      0,   32768,  32767, 1, -32768, 1);
        set_vec(7, -32768,      0,      0,      0,  -32768, -32768, 0, -32768, 0);
        set_vec(8,  16384,  16383,      0,      0,   32767,  32767, 0,  32767, 0);
        set_vec(9, -16384, -16385,      0,      0,  -32769, -32768, 1,  32767, 1);

        rst = 1'b1;
        ce  = 1'b1;
        apply(1'b0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // Reset state
        chk("reset full o_valid", int'(v_full), 0);
        chk("reset full o_sum",   int'(s_full), 0);
        chk("reset full o_ovf",   int'(o_full), 0);
        chk("reset sat o_valid",  int'(v_sat), 0);
        chk("reset sat o_sum",    int'(s_sat), 0);
        chk("reset sat o_ovf",    int'(o_sat), 0);
        chk("reset wrap o_valid", int'(v_wrap), 0);
        chk("reset wrap o_sum",   int'(s_wrap), 0);
        chk("reset wrap o_ovf",   int'(o_wrap), 0);
        chk("reset five o_valid", int'(v_five), 0);
        chk("reset five o_sum",   int'(s_five), 0);
        chk("reset five o_ovf",   int'(o_five), 0);
        clear_model();
        rst = 1'b0;
        tick();

        // Single sample: valid appears exactly three edges later, once.
        apply(1'b1, 32767, 32767, 32767, 32767, 0);
        tick();
        apply(1'b0, 0, 0, 0, 0, 0);
        chk("t1 o_valid edge1", int'(v_full), 0);
        tick();
        chk("t1 o_valid edge2", int'(v_full), 0);
        tick();
        chk("t1 o_valid edge3", int'(v_full), 1);
        chk("t1 o_sum", int'($signed(s_full)), 131068);
        chk("t1 o_ovf", int'(o_full), 0);
        tick();
        chk("t1 o_valid edge4", int'(v_full), 0);

        // Table vectors streamed back-to-back; entry c emerges after iteration c+2.
        for (int c = 0; c < 12; c++) begin
            if (c < 10) apply(1'b1, tbl[c].l0, tbl[c].l1, tbl[c].l2, tbl[c].l3, 0);
            else        apply(1'b0, 0, 0, 0, 0, 0);
            tick();
            if (c >= 2) begin
                chk($sformatf("tbl%0d full valid", c-2), int'(v_full), 1);
                chk($sformatf("tbl%0d full sum", c-2), int'($signed(s_full)), tbl[c-2].full);
                chk($sformatf("tbl%0d full ovf", c-2), int'(o_full), 0);
                chk($sformatf("tbl%0d sat sum", c-2), int'($signed(s_sat)), tbl[c-2].sat);
                chk($sformatf("tbl%0d sat ovf", c-2), int'(o_sat), tbl[c-2].sat_ovf);
                chk($sformatf("tbl%0d wrap sum", c-2), int'($signed(s_wrap)), tbl[c-2].wrap);
                chk($sformatf("tbl%0d wrap ovf", c-2), int'(o_wrap), tbl[c-2].wrap_ovf);
            end
        end

        // Drain, then the 5-lane latency check.
        apply(1'b0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        apply(1'b1, 1, 2, 3, 4, 5);
        tick();
        apply(1'b0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("t5 o_valid edge3", int'(v_five), 0);
        tick();
        chk("t5 o_valid edge4", int'(v_five), 1);
        chk("t5 o_sum", int'($signed(s_five)), 15);
        chk("t5 o_ovf", int'(o_five), 0);
        tick();
        chk("t5 o_valid edge5", int'(v_five), 0);
        repeat (4) tick();

        // Ten samples with a random clock enable: each sum exactly once, in order.
        for (int n = 0; n < 10; n++) begin
            exp5[n] = 0;
            for (int m = 0; m < 5; m++) begin
                s5l[n][m] = rnd_lane();
                exp5[n] += s5l[n][m];
            end
        end
        idx = 0;
        got.delete();
        for (int cyc = 0; cyc < 200 && got.size() < 10; cyc++) begin
            ce = ($urandom_range(0, 2) != 0);
            take = 1'b0;
            if (!ce) begin
                apply(1'b1, rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane());
            end else if (idx < 10) begin
                apply(1'b1, s5l[idx][0], s5l[idx][1], s5l[idx][2], s5l[idx][3], s5l[idx][4]);
                take = 1'b1;
            end else begin
                apply(1'b0, 0, 0, 0, 0, 0);
            end
            tick();
            if (take) idx++;
            if (ce && v_five) got.push_back(int'($signed(s_five)));
        end
        ce = 1'b1;
        chk("t5 stream count", got.size(), 10);
        for (int n = 0; n < 10 && n < got.size(); n++) begin
            chk($sformatf("t5 stream sum %0d", n), got[n], exp5[n]);
        end

        // Randomized traffic, checked by the monitor.
        for (int cyc = 0; cyc < 300; cyc++) begin
            ce = ($urandom_range(0, 3) != 0);
            apply(1'($urandom_range(0, 1)), rnd_lane(), rnd_lane(), rnd_lane(),
                  rnd_lane(), rnd_lane());
            tick();
        end
        ce = 1'b1;
        apply(1'b0, 0, 0, 0, 0, 0);
        repeat (5) tick();

        // Asynchronous reset with samples in flight.
        for (int n = 0; n < 3; n++) begin
            apply(1'b1, 1000 + n, 1000, 1000, 1000, 1000);
            tick();
        end
        chk("t6 pre-reset o_valid", int'(v_full), 1);
        chk("t6 pre-reset o_sum", int'($signed(s_full)), 4000);
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        chk("t6 async full o_valid", int'(v_full), 0);
        chk("t6 async full o_sum",   int'(s_full), 0);
        chk("t6 async sat o_valid",  int'(v_sat), 0);
        chk("t6 async sat o_sum",    int'(s_sat), 0);
        chk("t6 async wrap o_valid", int'(v_wrap), 0);
        chk("t6 async wrap o_sum",   int'(s_wrap), 0);
        chk("t6 async five o_valid", int'(v_five), 0);
        chk("t6 async five o_sum",   int'(s_five), 0);
        apply(1'b0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk($sformatf("t6 post full o_valid %0d", n), int'(v_full), 0);
            chk($sformatf("t6 post five o_valid %0d", n), int'(v_five), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
